axil_sync_ram_bridge: RTL and testbench
=======================================

# axil_sync_ram_bridge

AXI4-Lite subordinate that initiates accesses on the single-cycle synchronous RAM port (`raddr`/`waddr`/`wstrb`/`wdata`/`rdata`) used by the team's scratchpad RAMs. It is the bus-side driver placed in front of a RAM instance. It turns AXI4-Lite write and read transactions into RAM write strobes and registered reads, with independent read and write state machines.

## Interface
Parameters:
- `ADDR_WIDTH`, default 13. RAM word-address width; the byte address is sliced as `[ADDR_WIDTH+1:2]`.

Ports:
- `clock` in 1. Single clock; all logic is on the rising edge.
- `reset` in 1. Asynchronous, active-low reset.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1. Write-address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1. Write-data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1. Write-response channel.
- `araddr` in 32, `arvalid` in 1, `arready` out 1. Read-address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1. Read-data channel.
- `ram_waddr` out ADDR_WIDTH. RAM write word address.
- `ram_wstrb` out 4. RAM byte enables. Nonzero only in the commit cycle.
- `ram_wdata` out 32. RAM write data.
- `ram_raddr` out ADDR_WIDTH. RAM read word address.
- `ram_rdata` in 32. RAM read data, valid one clock edge after `ram_raddr` is sampled.

## Operation
Write path (states `W_IDLE`, `W_COMMIT`, `W_RESP`):
- AW and W are accepted independently into holding registers (`aw_held`, `w_held`).
  - `awready = !aw_held && state==W_IDLE`.
  - `wready = !w_held && state==W_IDLE`.
- When both are held, or both complete their handshakes on the same edge, the FSM moves to `W_COMMIT`.
- `W_COMMIT` lasts exactly one cycle and drives:
  - `ram_waddr = awaddr[ADDR_WIDTH+1:2]`
  - `ram_wdata`
  - `ram_wstrb` set to the captured strobe.
- A captured `wstrb` of 0 still completes with OKAY; no bytes are written.
- On the next edge the FSM enters `W_RESP` with `bvalid=1` and `bresp=2'b00`.
  - `bvalid` holds until `bready`.
  - The held flags clear, and the FSM returns to `W_IDLE`.
- `ram_wstrb` is 0 in every state except `W_COMMIT`. `ram_waddr` and `ram_wdata` hold their last values.

Read path (states `R_IDLE`, `R_ADDR`, `R_CAPT`, `R_RESP`):
- `arready=1` only in `R_IDLE`.
- On handshake, `ram_raddr <= araddr[ADDR_WIDTH+1:2]` and the FSM moves to `R_ADDR`.
- `R_ADDR` to `R_CAPT` on the next edge, while the RAM samples `ram_raddr`.
- `R_CAPT` to `R_RESP` on the next edge, with `rdata <= ram_rdata`, `rvalid=1`, and `rresp=2'b00`.
- `rvalid` and `rdata` hold until `rready`, then the FSM returns to `R_IDLE`.

Boundary conditions:
- Byte-address bits above `ADDR_WIDTH+1` are ignored, so the RAM aliases. Bits `[1:0]` are ignored.
- The read and write paths run concurrently on the separate RAM ports.
- Hazard: if `R_ADDR` coincides with `W_COMMIT` and the word addresses are equal, the read FSM stays in `R_ADDR` one extra cycle. The returned data therefore reflects the write.
- Reset mid-transaction:
  - All FSMs return to idle and held flags clear.
  - Pending responses are dropped and no partial RAM write occurs: `ram_wstrb` is forced to 0 asynchronously.
- Reset values while `reset` is low:
  - All valid and ready outputs are 0.
  - `bresp`, `rresp`, `rdata`, `ram_waddr`, `ram_wdata`, `ram_raddr` and `ram_wstrb` are all 0.
  - The ready outputs may rise in the first cycle after deassertion.

## Timing
- Write: both AW and W handshaken at edge E0. `ram_wstrb` is nonzero during the cycle E0–E1. `bvalid` rises after E1. With back-to-back `bready`, throughput is one write per 3 cycles.
- Read: AR handshaken at E0. `rvalid` rises after E2, giving 2-cycle latency. With `rready` held high, throughput is one read per 4 cycles.
- Hazard stall adds exactly one cycle to read latency.
- No combinational path from any input to a valid output. Ready outputs depend only on registered state.

## Test plan
- Word write: `awaddr=0x0`, `wdata=0xdeadbeef`, `wstrb=0xf`, then read 0x0 -> exactly one `ram_wstrb=0xf` cycle at `ram_waddr=0`, `bresp=0`, and `rdata=0xdeadbeef` 2 cycles after the AR handshake.
- Partial strobes: write `0xdeadbeef` with `wstrb` 0x3 @0x4, 0xc @0x8, 0x1 @0xc, 0x2 @0x10, each to zeroed RAM, then read each back -> 0x0000beef, 0xdead0000, 0x000000ef, 0x0000be00.
- Decoupled channels: W presented 5 cycles before AW, and separately AW 5 cycles before W -> commit occurs only once both are held, with a single `bvalid` pulse each time.
- Backpressure: `bready` and `rready` held low for 10 cycles -> `bvalid`, `rvalid` and `rdata` stay stable, no new AW/W/AR is accepted, and `ram_wstrb` stays 0.
- Hazard: read 0x20 issued so that `R_ADDR` coincides with a commit of `0x12345678` to 0x20 -> `rdata=0x12345678`, with latency 3 cycles.
- Reset mid-operation: assert `reset` low during `W_COMMIT` and during `R_CAPT` -> all outputs are 0 immediately, and a subsequent read of that address returns the pre-write contents.

Source files
------------

// File: rtl/axil_sync_ram_bridge.sv
// AXI4-Lite subordinate driving a single-cycle synchronous RAM port.
// The write path collects AW and W independently, then spends one cycle
// strobing the RAM before answering on B. The read path registers the word
// address, waits one edge for the RAM to sample it, then captures the RAM
// output into the R channel. Both paths run concurrently on separate RAM
// ports. A read whose address phase overlaps a commit to the same word
// waits one extra cycle so that it returns the freshly written data.
//
// Handshake rule on every channel: a transfer happens on the rising edge
// where valid and ready are both high. Once asserted, a valid output is held
// with stable payload until that edge. Ready outputs are pure functions of
// registered state, and no input reaches a valid output combinationally.
module axil_sync_ram_bridge #(
    parameter int ADDR_WIDTH = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    // write address channel
    input  logic [31:0]           awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    // write data channel
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    // write response channel
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    // read address channel
    input  logic [31:0]           araddr,
    input  logic                  arvalid,
    output logic                  arready,
    // read data channel
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    // RAM port
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [3:0]            ram_wstrb,
    output logic [31:0]           ram_wdata,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [31:0]           ram_rdata,
    // FSM state visibility
    output logic [1:0]            dbg_w_state_o,
    output logic [1:0]            dbg_r_state_o
);

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_CAPT = 2'd2,
        R_RESP = 2'd3
    } r_state_e;

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;

    logic                  ready_en_q;
    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_held_q, w_held_d;
    logic [31:0]           w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;

    logic [ADDR_WIDTH-1:0] ram_waddr_q, ram_waddr_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;
    logic [3:0]            commit_strb_q, commit_strb_d;

    logic [ADDR_WIDTH-1:0] ram_raddr_q, ram_raddr_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  aw_fire;
    logic                  w_fire;
    logic                  ar_fire;
    logic                  hazard;
    logic                  unused_addr_bits;

    // Word addresses only: upper bits alias, byte-offset bits are dropped.
    assign unused_addr_bits = ^{awaddr[31:ADDR_WIDTH+2], awaddr[1:0],
                                araddr[31:ADDR_WIDTH+2], araddr[1:0]};

    assign awready = ready_en_q && !aw_held_q && (w_state_q == W_IDLE);
    assign wready  = ready_en_q && !w_held_q  && (w_state_q == W_IDLE);
    assign arready = ready_en_q && (r_state_q == R_IDLE);

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid  && wready;
    assign ar_fire = arvalid && arready;

    assign bvalid    = (w_state_q == W_RESP);
    assign bresp     = 2'b00;
    assign rvalid    = (r_state_q == R_RESP);
    assign rresp     = 2'b00;
    assign rdata     = rdata_q;
    assign ram_waddr = ram_waddr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_raddr = ram_raddr_q;
    // Strobes come straight from state, so reset kills them without a clock.
    assign ram_wstrb = (w_state_q == W_COMMIT) ? commit_strb_q : 4'h0;

    assign dbg_w_state_o = w_state_q;
    assign dbg_r_state_o = r_state_q;

    // Same-word read overlapping a commit: RAM would return the old word.
    assign hazard = (w_state_q == W_COMMIT) && (ram_waddr_q == ram_raddr_q);

    // Keeps all readies low during reset and releases them one edge later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    // Write path next state: gather AW and W, commit once, then respond.
    always_comb begin
        w_state_d     = w_state_q;
        aw_held_d     = aw_held_q;
        aw_addr_d     = aw_addr_q;
        w_held_d      = w_held_q;
        w_data_d      = w_data_q;
        w_strb_d      = w_strb_q;
        ram_waddr_d   = ram_waddr_q;
        ram_wdata_d   = ram_wdata_q;
        commit_strb_d = commit_strb_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = awaddr[ADDR_WIDTH+1:2];
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d     = W_COMMIT;
                    ram_waddr_d   = aw_addr_d;
                    ram_wdata_d   = w_data_d;
                    commit_strb_d = w_strb_d;
                end
            end
            W_COMMIT: w_state_d = W_RESP;
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write path registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_q     <= W_IDLE;
            aw_held_q     <= 1'b0;
            aw_addr_q     <= '0;
            w_held_q      <= 1'b0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            ram_waddr_q   <= '0;
            ram_wdata_q   <= '0;
            commit_strb_q <= '0;
        end else begin
            w_state_q     <= w_state_d;
            aw_held_q     <= aw_held_d;
            aw_addr_q     <= aw_addr_d;
            w_held_q      <= w_held_d;
            w_data_q      <= w_data_d;
            w_strb_q      <= w_strb_d;
            ram_waddr_q   <= ram_waddr_d;
            ram_wdata_q   <= ram_wdata_d;
            commit_strb_q <= commit_strb_d;
        end
    end

    // Read path next state: address, RAM sample, capture, respond.
    always_comb begin
        r_state_d   = r_state_q;
        ram_raddr_d = ram_raddr_q;
        rdata_d     = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    ram_raddr_d = araddr[ADDR_WIDTH+1:2];
                    r_state_d   = R_ADDR;
                end
            end
            R_ADDR: begin
                if (!hazard) r_state_d = R_CAPT;
            end
            R_CAPT: begin
                rdata_d   = ram_rdata;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read path registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_q   <= R_IDLE;
            ram_raddr_q <= '0;
            rdata_q     <= '0;
        end else begin
            r_state_q   <= r_state_d;
            ram_raddr_q <= ram_raddr_d;
            rdata_q     <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axil_sync_ram_bridge.sv
// Directed bench for axil_sync_ram_bridge with a behavioural read-first RAM.
`timescale 1ns/1ps
module tb_axil_sync_ram_bridge;

    localparam int AW = 13;

    // ---------------- clock / reset / signals ----------------
    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [31:0]   araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [AW-1:0] ram_waddr;
    logic [3:0]    ram_wstrb;
    logic [31:0]   ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [31:0]   ram_rdata;
    logic [1:0]    dbg_w_state;
    logic [1:0]    dbg_r_state;

    bit [31:0]     mem [0:(1<<AW)-1];
    int            checks = 0;
    int            failures = 0;
    int            wstrb_cycles = 0;
    int            bvalid_rises = 0;
    logic          bvalid_prev = 1'b0;

    always #5 clock = ~clock;

    axil_sync_ram_bridge #(.ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .ram_waddr(ram_waddr), .ram_wstrb(ram_wstrb), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .dbg_w_state_o(dbg_w_state), .dbg_r_state_o(dbg_r_state)
    );

    // Synchronous RAM: read returns the pre-write word on a same-edge collision.
    always @(posedge clock) begin
        ram_rdata <= mem[ram_raddr];
        for (int b = 0; b < 4; b++)
            if (ram_wstrb[b]) mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    // Monitors: strobe cycles and bvalid rising edges.
    always @(negedge clock) begin
        if (ram_wstrb != 4'h0) wstrb_cycles <= wstrb_cycles + 1;
        if (bvalid && !bvalid_prev) bvalid_rises <= bvalid_rises + 1;
        bvalid_prev <= bvalid;
    end

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             output logic [3:0] c_strb, output logic [AW-1:0] c_waddr,
                             output logic [31:0] c_wdata, output logic [1:0] c_bresp,
                             output int hs_cyc, output int b_lat);
        bit aw_done, w_done, aw_f, w_f;
        int n;
        aw_done = 0; w_done = 0; n = 0; b_lat = -1; c_bresp = 2'bxx;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && n < 50) begin
            awvalid = !aw_done && (n >= aw_dly);
            wvalid  = !w_done && (n >= w_dly);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clock); #1;
            if (aw_f) aw_done = 1;
            if (w_f) w_done = 1;
            n++;
        end
        awvalid = 0; wvalid = 0;
        hs_cyc = n;
        c_strb = ram_wstrb; c_waddr = ram_waddr; c_wdata = ram_wdata;
        if (aw_done && w_done) begin
            for (int k = 1; k <= 20; k++) begin
                @(posedge clock); #1;
                if (bvalid) begin b_lat = k; break; end
            end
            c_bresp = bresp;
            bready = 1; @(posedge clock); #1; bready = 0;
        end
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        bit ar_f;
        int n;
        ar_f = 0; n = 0; lat = -1; data = 'x; resp = 'x;
        araddr = addr; arvalid = 1;
        while (!ar_f && n < 50) begin
            ar_f = arready;
            @(posedge clock); #1;
            n++;
        end
        arvalid = 0;
        if (ar_f) begin
            for (int k = 1; k <= 20; k++) begin
                @(posedge clock); #1;
                if (rvalid) begin lat = k; break; end
            end
            data = rdata; resp = rresp;
            rready = 1; @(posedge clock); #1; rready = 0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
             ram_waddr, ram_wdata, ram_raddr, ram_wstrb} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", {awready, wready, arready,
                     bvalid, rvalid, bresp, rresp, rdata, ram_waddr, ram_wdata, ram_raddr, ram_wstrb});
        end
        reset = 1;
        @(posedge clock); #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            failures++;
            $display("FAIL readies_after_reset: got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_word_write();
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d, rd; logic [1:0] br, rr;
        int hs, bl, lat, w0;
        w0 = wstrb_cycles;
        axi_write(32'h0, 32'hdeadbeef, 4'hf, 0, 0, s, a, d, br, hs, bl);
        checks++;
        if ({s, a, d} !== {4'hf, 13'h0, 32'hdeadbeef}) begin
            failures++;
            $display("FAIL word_commit: strb=%h addr=%h data=%h required f/0/deadbeef", s, a, d);
        end
        checks++;
        if (bl !== 1 || br !== 2'b00) begin
            failures++;
            $display("FAIL word_bresp: lat=%0d bresp=%b required 1/00", bl, br);
        end
        checks++;
        if (wstrb_cycles - w0 !== 1) begin
            failures++;
            $display("FAIL word_strobe_count: got %0d required 1", wstrb_cycles - w0);
        end
        axi_read(32'h0, rd, rr, lat);
        checks++;
        if (rd !== 32'hdeadbeef || lat !== 2 || rr !== 2'b00) begin
            failures++;
            $display("FAIL word_read: data=%h lat=%0d rresp=%b required deadbeef/2/00", rd, lat, rr);
        end
    endtask

    task automatic test_partial_strobes();
        logic [31:0] exp_q[$];
        logic [31:0] addrs[4] = '{32'h4, 32'h8, 32'hc, 32'h10};
        logic [3:0]  strbs[4] = '{4'h3, 4'hc, 4'h1, 4'h2};
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d, rd, e; logic [1:0] br, rr;
        int hs, bl, lat;
        exp_q.push_back(32'h0000beef);
        exp_q.push_back(32'hdead0000);
        exp_q.push_back(32'h000000ef);
        exp_q.push_back(32'h0000be00);
        for (int i = 0; i < 4; i++) begin
            axi_write(addrs[i], 32'hdeadbeef, strbs[i], 0, 0, s, a, d, br, hs, bl);
            checks++;
            if (s !== strbs[i] || a !== addrs[i][AW+1:2]) begin
                failures++;
                $display("FAIL partial_commit%0d: strb=%h addr=%h required %h/%h",
                         i, s, a, strbs[i], addrs[i][AW+1:2]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], rd, rr, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin
                failures++;
                $display("FAIL partial_read%0d: got %h required %h", i, rd, e);
            end
        end
    endtask

    task automatic test_zero_strobe();
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d, rd; logic [1:0] br, rr;
        int hs, bl, lat, w0;
        w0 = wstrb_cycles;
        axi_write(32'h14, 32'hffffffff, 4'h0, 0, 0, s, a, d, br, hs, bl);
        checks++;
        if (bl !== 1 || br !== 2'b00 || wstrb_cycles - w0 !== 0) begin
            failures++;
            $display("FAIL zero_strobe_resp: lat=%0d bresp=%b strobes=%0d required 1/00/0",
                     bl, br, wstrb_cycles - w0);
        end
        axi_read(32'h14, rd, rr, lat);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL zero_strobe_read: got %h required 0", rd);
        end
    endtask

    task automatic test_alias();
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d, rd; logic [1:0] br, rr;
        int hs, bl, lat;
        axi_write(32'hffff8053, 32'hcafef00d, 4'hf, 0, 0, s, a, d, br, hs, bl);
        checks++;
        if (a !== 13'h0014) begin
            failures++;
            $display("FAIL alias_waddr: got %h required 0014", a);
        end
        axi_read(32'h00000050, rd, rr, lat);
        checks++;
        if (rd !== 32'hcafef00d) begin
            failures++;
            $display("FAIL alias_read: got %h required cafef00d", rd);
        end
    endtask

    task automatic test_decoupled();
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d, rd; logic [1:0] br, rr;
        int hs, bl, lat, w0, b0;
        // W first, AW five cycles later
        w0 = wstrb_cycles; b0 = bvalid_rises;
        axi_write(32'h60, 32'h01020304, 4'hf, 5, 0, s, a, d, br, hs, bl);
        checks++;
        if (hs !== 6 || s !== 4'hf || wstrb_cycles - w0 !== 1 || bvalid_rises - b0 !== 1) begin
            failures++;
            $display("FAIL decoupled_w_first: hs=%0d strb=%h strobes=%0d bpulses=%0d required 6/f/1/1",
                     hs, s, wstrb_cycles - w0, bvalid_rises - b0);
        end
        // AW first, W five cycles later
        w0 = wstrb_cycles; b0 = bvalid_rises;
        axi_write(32'h64, 32'h0a0b0c0d, 4'hf, 0, 5, s, a, d, br, hs, bl);
        checks++;
        if (hs !== 6 || d !== 32'h0a0b0c0d || wstrb_cycles - w0 !== 1 || bvalid_rises - b0 !== 1) begin
            failures++;
            $display("FAIL decoupled_aw_first: hs=%0d data=%h strobes=%0d bpulses=%0d required 6/0a0b0c0d/1/1",
                     hs, d, wstrb_cycles - w0, bvalid_rises - b0);
        end
        axi_read(32'h60, rd, rr, lat);
        checks++;
        if (rd !== 32'h01020304) begin
            failures++;
            $display("FAIL decoupled_read: got %h required 01020304", rd);
        end
    endtask

    task automatic test_hazard();
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d, rd; logic [1:0] br, rr;
        int hs, bl, lat;
        // same word: read address phase overlaps the commit
        fork
            axi_write(32'h20, 32'h12345678, 4'hf, 0, 0, s, a, d, br, hs, bl);
            axi_read(32'h20, rd, rr, lat);
        join
        checks++;
        if (rd !== 32'h12345678 || lat !== 3) begin
            failures++;
            $display("FAIL hazard_read: data=%h lat=%0d required 12345678/3", rd, lat);
        end
        // different words: no stall
        fork
            axi_write(32'h24, 32'h55aa55aa, 4'hf, 0, 0, s, a, d, br, hs, bl);
            axi_read(32'h28, rd, rr, lat);
        join
        checks++;
        if (rd !== 32'h0 || lat !== 2) begin
            failures++;
            $display("FAIL concurrent_read: data=%h lat=%0d required 0/2", rd, lat);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d; logic [1:0] br;
        int hs, bl;
        axi_write(32'h34, 32'h0badf00d, 4'hf, 0, 0, s, a, d, br, hs, bl);
        awaddr = 32'h30; wdata = 32'ha5a50f0f; wstrb = 4'hf; araddr = 32'h34;
        awvalid = 1; wvalid = 1; arvalid = 1;
        @(posedge clock); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        repeat (2) @(posedge clock);
        #1;
        awaddr = 32'h38; araddr = 32'h38; wdata = 32'hffffffff;
        awvalid = 1; wvalid = 1; arvalid = 1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({bvalid, rvalid, awready, wready, arready, ram_wstrb, rdata} !==
                {5'b11000, 4'h0, 32'h0badf00d}) begin
                failures++;
                $display("FAIL backpressure_hold%0d: bv=%b rv=%b rdy=%b%b%b strb=%h rdata=%h required 1/1/000/0/0badf00d",
                         i, bvalid, rvalid, awready, wready, arready, ram_wstrb, rdata);
            end
            @(posedge clock); #1;
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        bready = 1; rready = 1;
        @(posedge clock); #1;
        bready = 0; rready = 0;
        checks++;
        if ({bvalid, rvalid} !== 2'b00) begin
            failures++;
            $display("FAIL backpressure_release: bv=%b rv=%b required 0/0", bvalid, rvalid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] s; logic [AW-1:0] a; logic [31:0] d, rd; logic [1:0] br, rr;
        int hs, bl, lat;
        axi_write(32'h40, 32'h11111111, 4'hf, 0, 0, s, a, d, br, hs, bl);
        // reset during W_COMMIT
        awaddr = 32'h40; wdata = 32'h99999999; wstrb = 4'hf;
        awvalid = 1; wvalid = 1;
        @(posedge clock); #1;
        awvalid = 0; wvalid = 0;
        checks++;
        if (ram_wstrb !== 4'hf) begin
            failures++;
            $display("FAIL reset_w_commit_entry: strb=%h required f", ram_wstrb);
        end
        reset = 0; #1;
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata,
             ram_waddr, ram_wdata, ram_raddr, ram_wstrb} !== '0) begin
            failures++;
            $display("FAIL reset_during_commit: got %h required 0", {awready, wready, arready,
                     bvalid, rvalid, bresp, rresp, rdata, ram_waddr, ram_wdata, ram_raddr, ram_wstrb});
        end
        repeat (2) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1;
        axi_read(32'h40, rd, rr, lat);
        checks++;
        if (rd !== 32'h11111111) begin
            failures++;
            $display("FAIL reset_write_dropped: got %h required 11111111", rd);
        end
        // reset during R_CAPT
        araddr = 32'h40; arvalid = 1;
        @(posedge clock); #1;
        arvalid = 0;
        @(posedge clock); #1;
        checks++;
        if (dbg_r_state !== 2'd2) begin
            failures++;
            $display("FAIL reset_r_capt_entry: state=%0d required 2", dbg_r_state);
        end
        reset = 0; #1;
        checks++;
        if ({arready, rvalid, rresp, rdata, ram_raddr} !== '0) begin
            failures++;
            $display("FAIL reset_during_capt: arready=%b rvalid=%b rdata=%h raddr=%h required 0",
                     arready, rvalid, rdata, ram_raddr);
        end
        repeat (2) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1;
        axi_read(32'h40, rd, rr, lat);
        checks++;
        if (rd !== 32'h11111111 || lat !== 2) begin
            failures++;
            $display("FAIL reset_read_after: data=%h lat=%0d required 11111111/2", rd, lat);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arvalid = 0; rready = 0;
        test_reset();
        test_word_write();
        test_partial_strobes();
        test_zero_strobe();
        test_alias();
        test_decoupled();
        test_hazard();
        test_backpressure();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
